// File: rtl/soc_system_led_pio_pwm_if.sv
// Avalon-MM slave bus bundle for the LED PIO: word address, chip select, write strobe, data.
// Latency: none, wires only; readdata is driven combinationally by the slave.
// Backpressure: none, no waitrequest, so every access completes in one cycle.
interface soc_system_led_pio_pwm_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_led_pio_pwm.sv
// LED output PIO with static level, set/clear, per-channel blink and global PWM brightness.
// Latency: register write lands on the write edge and reaches out_port on the following edge.
// Backpressure: none, writes are accepted every cycle and reads are zero-latency.
module soc_system_led_pio_pwm #(
  parameter int                    WIDTH          = 8,
  parameter int                    DUTY_W         = 8,
  parameter int                    PRESCALE_W     = 24,
  parameter logic [WIDTH-1:0]      RESET_VALUE    = '0,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  soc_system_led_pio_pwm_if.slave  bus,
  output logic [WIDTH-1:0]         out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUTSET   = 3'd1;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd2;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
  localparam logic [2:0] ADDR_DUTY     = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  logic [WIDTH-1:0]      data_reg;
  logic [WIDTH-1:0]      blink_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [DUTY_W-1:0]     duty;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [DUTY_W-1:0]     pwm_cnt;
  logic                  phase;
  logic                  wr;
  logic                  pwm_on;
  logic [WIDTH-1:0]      wr_field;
  logic [31:0]           rd;

  assign wr       = bus.chipselect && !bus.write_n;
  assign wr_field = bus.writedata[WIDTH-1:0];
  assign pwm_on   = (duty == '1) || (pwm_cnt < duty);

  // Static level register: direct write, atomic set and atomic clear share one register.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:   data_reg <= wr_field;
        ADDR_OUTSET: data_reg <= data_reg | wr_field;
        ADDR_OUTCLR: data_reg <= data_reg & ~wr_field;
        default:     data_reg <= data_reg;
      endcase
    end
  end

  // Configuration registers; upper writedata bits beyond each field are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_en <= '0;
      prescale <= PRESCALE_RESET;
      duty     <= '1;
    end else if (wr) begin
      if (bus.address == ADDR_BLINK_EN) blink_en <= wr_field;
      if (bus.address == ADDR_PRESCALE) prescale <= bus.writedata[PRESCALE_W-1:0];
      if (bus.address == ADDR_DUTY)     duty     <= bus.writedata[DUTY_W-1:0];
    end
  end

  // Blink prescaler; a PRESCALE write restarts the half-period and beats a coincident wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      phase     <= 1'b1;
    end else if (wr && (bus.address == ADDR_PRESCALE)) begin
      presc_cnt <= '0;
      phase     <= 1'b1;
    end else if (presc_cnt == prescale) begin
      presc_cnt <= '0;
      phase     <= ~phase;
    end else begin
      presc_cnt <= presc_cnt + PRESCALE_W'(1);
    end
  end

  // PWM counter free-runs over the full 2**DUTY_W period.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
    end
  end

  // Registered LED drive: static level gated by blink phase (where enabled) and PWM.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= '0;
    end else begin
      out_port <= data_reg & (~blink_en | {WIDTH{phase}}) & {WIDTH{pwm_on}};
    end
  end

  // Zero-latency read mux; chipselect is not needed for read data.
  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_DATA:     rd[WIDTH-1:0]      = data_reg;
      ADDR_BLINK_EN: rd[WIDTH-1:0]      = blink_en;
      ADDR_PRESCALE: rd[PRESCALE_W-1:0] = prescale;
      ADDR_DUTY:     rd[DUTY_W-1:0]     = duty;
      ADDR_STATUS:   rd[0]              = phase;
      default:       rd                 = '0;
    endcase
    bus.readdata = rd;
  end

endmodule

// File: tb/tb_soc_system_led_pio_pwm.sv
// Directed self-checking bench for the LED PIO: register map vectors plus blink/PWM/reset sequences.
// Latency: inputs driven on the falling edge, outputs sampled on or just after the falling edge.
// Backpressure: none on this bus; every access is a single-cycle operation.
module tb_soc_system_led_pio_pwm;

  localparam int OP_W = 0;  // bus write
  localparam int OP_R = 1;  // combinational readback compare
  localparam int OP_O = 2;  // advance one clock, compare out_port

  typedef struct {
    int          op;
    logic [2:0]  addr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] out_port;
  int         n_total;
  int         n_pass;
  vec_t       vecs[26];

  soc_system_led_pio_pwm_if bus ();

  soc_system_led_pio_pwm #(
    .WIDTH          (8),
    .DUTY_W         (8),
    .PRESCALE_W     (24),
    .RESET_VALUE    (8'hA5),
    .PRESCALE_RESET (24'd0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] dat);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = dat;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] dat);
    bus.address = addr;
    #1;
    dat = bus.readdata;
  endtask

  // Expected pattern for PRESCALE=3 counted from the negedge right after the PRESCALE write.
  task automatic check_blink(input string tag);
    logic [31:0] rd;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      bus_read(3'd6, rd);
      check($sformatf("%s_status%0d", tag, j), rd, {31'd0, ((j / 4) % 2) == 0});
      if (j >= 1)
        check($sformatf("%s_out%0d", tag, j), {24'd0, out_port},
              {24'd0, 7'h7F, (((j - 1) / 4) % 2) == 0});
    end
  endtask

  task automatic count_pwm(input string name, input int exp_high);
    int high;
    high = 0;
    @(negedge clk);  // let out_port pick up the last register write
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (out_port[0]) high++;
    end
    check(name, high, exp_high);
  endtask

  initial begin
    logic [31:0] rd;
    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{OP_W, 3'd0, 32'h0000_000F, 32'h0};
    vecs[1]  = '{OP_W, 3'd1, 32'h0000_00F0, 32'h0};
    vecs[2]  = '{OP_W, 3'd2, 32'h0000_0003, 32'h0};
    vecs[3]  = '{OP_R, 3'd0, 32'h0,         32'h0000_00FC};
    vecs[4]  = '{OP_R, 3'd1, 32'h0,         32'h0};
    vecs[5]  = '{OP_R, 3'd2, 32'h0,         32'h0};
    vecs[6]  = '{OP_O, 3'd0, 32'h0,         32'h0000_00FC};
    vecs[7]  = '{OP_W, 3'd0, 32'hFFFF_FF3C, 32'h0};
    vecs[8]  = '{OP_R, 3'd0, 32'h0,         32'h0000_003C};
    vecs[9]  = '{OP_O, 3'd0, 32'h0,         32'h0000_003C};
    vecs[10] = '{OP_W, 3'd6, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{OP_W, 3'd7, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{OP_R, 3'd0, 32'h0,         32'h0000_003C};
    vecs[13] = '{OP_R, 3'd7, 32'h0,         32'h0};
    vecs[14] = '{OP_R, 3'd3, 32'h0,         32'h0};
    vecs[15] = '{OP_O, 3'd0, 32'h0,         32'h0000_003C};
    vecs[16] = '{OP_W, 3'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[17] = '{OP_R, 3'd3, 32'h0,         32'h0000_00FF};
    vecs[18] = '{OP_W, 3'd3, 32'h0,         32'h0};
    vecs[19] = '{OP_W, 3'd4, 32'hFF00_0005, 32'h0};
    vecs[20] = '{OP_R, 3'd4, 32'h0,         32'h0000_0005};
    vecs[21] = '{OP_W, 3'd5, 32'hFFFF_FF40, 32'h0};
    vecs[22] = '{OP_R, 3'd5, 32'h0,         32'h0000_0040};
    vecs[23] = '{OP_W, 3'd5, 32'h0000_00FF, 32'h0};
    vecs[24] = '{OP_R, 3'd5, 32'h0,         32'h0000_00FF};
    vecs[25] = '{OP_O, 3'd0, 32'h0,         32'h0000_003C};

    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    reset          = 1'b1;

    // Reset: outputs low while held, RESET_VALUE one clock after release.
    repeat (3) @(negedge clk);
    check("rst_out_held", {24'd0, out_port}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_release", {24'd0, out_port}, 32'h0000_00A5);
    bus_read(3'd5, rd);
    check("rst_duty", rd, 32'h0000_00FF);
    bus_read(3'd0, rd);
    check("rst_data", rd, 32'h0000_00A5);
    bus_read(3'd4, rd);
    check("rst_prescale", rd, 32'h0);

    // Register map vectors.
    for (int i = 0; i < 26; i++) begin
      case (vecs[i].op)
        OP_W: bus_write(vecs[i].addr, vecs[i].dat);
        OP_R: begin
          bus_read(vecs[i].addr, rd);
          check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
        end
        default: begin
          @(negedge clk);
          check($sformatf("vec%0d_out", i), {24'd0, out_port}, vecs[i].exp);
        end
      endcase
    end

    // Blink on channel 0, then a mid-period PRESCALE rewrite restarts at phase 1.
    bus_write(3'd0, 32'h0000_00FF);
    bus_write(3'd3, 32'h0000_0001);
    bus_write(3'd4, 32'h0000_0003);
    check_blink("blink");
    bus_read(3'd6, rd);
    check("status_upper_zero", rd & 32'hFFFF_FFFE, 32'h0);
    @(negedge clk);
    @(negedge clk);
    bus_write(3'd4, 32'h0000_0003);
    check_blink("reblink");

    // Reset mid-blink: phase back to 1, then PRESCALE_RESET=0 toggles every clock.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_read(3'd6, rd);
    check("midrst_phase", rd, 32'h1);
    check("midrst_out", {24'd0, out_port}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    bus_read(3'd6, rd);
    check("postrst_phase1", rd, 32'h0);
    check("postrst_out", {24'd0, out_port}, 32'h0000_00A5);
    @(negedge clk);
    bus_read(3'd6, rd);
    check("postrst_phase2", rd, 32'h1);
    bus_read(3'd3, rd);
    check("postrst_blink_en", rd, 32'h0);

    // PWM brightness on channel 0 over full 256-clock windows.
    bus_write(3'd0, 32'h0000_0001);
    bus_write(3'd5, 32'h0000_0040);
    count_pwm("pwm_duty64", 64);
    count_pwm("pwm_duty64_again", 64);
    bus_write(3'd5, 32'h0000_0001);
    count_pwm("pwm_duty1", 1);
    bus_write(3'd5, 32'h0000_0000);
    count_pwm("pwm_duty0", 0);
    bus_write(3'd5, 32'h0000_00FF);
    count_pwm("pwm_dutyff", 256);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
